t03_gpio_arbiter: RTL and testbench
===================================

Name: t03_gpio_arbiter

Overview:
- Shares the 34-bit breakout GPIO output bank (gpio_out/gpio_oeb) between NREQ on-chip requesters.
- Uses a round-robin request/grant handshake.
- Sits between team_03 functional submodules and the top-level gpio_out/gpio_oeb pins.
- Registers the winning requester's drive values and inserts one tri-state turnaround cycle between owners, so two owners never drive back-to-back.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 34, GPIO bank width.
- MAX_HOLD, 255, maximum consecutive owned cycles before forced release (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- nrst  input  1  asynchronous active-low reset.
- en  input  1  chip enable; low disables the arbiter.
- req  input  NREQ  per-requester bus request; level, held for the whole ownership.
- req_out  input  NREQ*WIDTH  requester drive values; slice i is [i*WIDTH +: WIDTH].
- req_oeb  input  NREQ*WIDTH  requester active-low output enables, same slicing.
- gpio_out  output  WIDTH  registered pin drive values.
- gpio_oeb  output  WIDTH  registered active-low pin enables.
- grant  output  NREQ  one-hot registered grant; all zero when nobody owns the bus.
- busy  output  1  high in OWN and TURN.
- timeout  output  1  one-cycle pulse on forced release; tied 0 without the macro.

Behaviour:
- Reset (nrst low, asynchronous):
  - state=IDLE, grant=0, gpio_out=0, gpio_oeb=all ones (pins tri-stated), busy=0, timeout=0.
  - rr_ptr=0, hold counter=0.
- State IDLE:
  - grant=0, gpio_oeb=all ones, gpio_out=0.
  - If en and any req: pick the first asserted req[i] searching upward from rr_ptr with wrap.
  - Next cycle: grant[i]=1, state=OWN, busy=1.
- State OWN (owner k):
  - Each cycle gpio_out<=req_out slice k and gpio_oeb<=req_oeb slice k. Pins reflect requester values with 1-cycle latency.
  - The first registered pin values appear the cycle after grant rises.
  - When req[k] is sampled low: state=TURN, grant=0, rr_ptr<=(k+1) mod NREQ.
  - Other requesters' req changes while in OWN are ignored; no preemption.
- State TURN (exactly 1 cycle):
  - gpio_oeb=all ones, gpio_out=0, grant=0, busy=1.
  - Then state=IDLE.
  - Minimum gap between two grants is 2 cycles (TURN + IDLE).
- Arbitration fairness: with all requesters continuously requesting, the grant order is 0,1,2,3,0,... Each requester waits at most NREQ-1 ownerships.
- req[k] dropping the same cycle it is granted: OWN lasts one cycle, then TURN. Legal.
- en low (synchronous, any state):
  - Next cycle state=IDLE, grant=0, gpio_oeb=all ones, gpio_out=0, busy=0.
  - rr_ptr is kept.
  - No TURN is inserted, because the pins are tri-stated immediately.
- Reset mid-ownership: outputs go to reset values immediately (asynchronous); rr_ptr returns to 0.
- Requester index wrap: searching from rr_ptr=3 with only req[1] set grants 1.

Optional Feature:
- Macro: T03_GPIO_ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit hold counter clears on entry to OWN and increments each OWN cycle.
  - When the counter reaches MAX_HOLD with req[k] still high: forced transition to TURN, timeout=1 for that one cycle, rr_ptr advances past k.
  - Requester k is then masked from arbitration until it deasserts req for at least one cycle.
- When undefined:
  - No counter or mask logic is built.
  - timeout is constant 0.
  - Ownership is unbounded.

Test Plan:
- Reset/idle: assert nrst=0 with req=4'b1111 → grant=0, gpio_oeb=34'h3_FFFF_FFFF, gpio_out=0, busy=0. After release with en=0, req=4'b1111 → state stays IDLE, grant=0.
- Single owner: en=1, req=4'b0100, slice 2 out=34'h1_2345_6789, oeb=0.
  - Cycle+1: grant=4'b0100.
  - Cycle+2: gpio_out=34'h1_2345_6789, gpio_oeb=0.
  - Drop req[2] → one TURN cycle with gpio_oeb all ones, then IDLE.
- Round-robin: req=4'b1111 held, each owner releases after 3 cycles → grant sequence 0001,0010,0100,1000,0001. Exactly 2 grant-zero cycles between owners.
- Wrap and priority: after owner 3 releases, req=4'b0011 → grant=4'b0001. After owner 0 releases with req=4'b0011 still set → grant=4'b0010.
- en drop mid-OWN: owner 1 driving oeb=0, pull en low → next cycle grant=0, gpio_oeb all ones, busy=0. Raise en with req[1] still high → regranted after 1 cycle.
- Timeout (macro on, MAX_HOLD=4): req[0] stuck high, req[1] high.
  - timeout pulses once after 4 OWN cycles, then TURN.
  - grant=4'b0010 follows.
  - req[0] is not regranted until it toggles low then high.

Source files
------------

// File: rtl/t03_gpio_arbiter.sv
// t03_gpio_arbiter: round-robin owner of the shared GPIO output bank.
// Define T03_GPIO_ARB_TIMEOUT_EN to bound ownership at MAX_HOLD cycles.
module t03_gpio_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 34,
  parameter int MAX_HOLD = 255
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_out,
  input  logic [NREQ*WIDTH-1:0] req_oeb,
  output logic [WIDTH-1:0]      gpio_out,
  output logic [WIDTH-1:0]      gpio_oeb,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  timeout
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    TURN
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   nxt_ptr;
  logic            pick_vld;
  logic [NREQ-1:0] pick_hot;
  logic [NREQ-1:0] cand;
  logic [WIDTH-1:0] own_out;
  logic [WIDTH-1:0] own_oeb;
  logic            own_req;
  logic            force_rel;

  // First candidate at or above rr_ptr, wrapping; lowest offset wins.
  always_comb begin
    logic [PW:0] sum;
    logic [PW-1:0] idx;
    pick_vld = 1'b0;
    pick     = rr_ptr;
    sum      = '0;
    idx      = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(j);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      idx = sum[PW-1:0];
      if (cand[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    pick_hot = '0;
    own_out  = '0;
    own_oeb  = '1;
    own_req  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pick_hot[i] = (pick == PW'(i));
      if (owner == PW'(i)) begin
        own_out = req_out[i*WIDTH +: WIDTH];
        own_oeb = req_oeb[i*WIDTH +: WIDTH];
        own_req = req[i];
      end
    end
  end

  assign nxt_ptr = (int'(owner) == NREQ - 1) ?
                   '0 : owner + 1'b1;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      grant    <= '0;
      gpio_out <= '0;
      gpio_oeb <= '1;
      busy     <= 1'b0;
      rr_ptr   <= '0;
      owner    <= '0;
    end else if (!en) begin
      // Pins tri-state at once, so no turnaround is needed.
      state    <= IDLE;
      grant    <= '0;
      gpio_out <= '0;
      gpio_oeb <= '1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state <= OWN;
            owner <= pick;
            grant <= pick_hot;
            busy  <= 1'b1;
          end
        end
        OWN: begin
          if (!own_req || force_rel) begin
            state    <= TURN;
            grant    <= '0;
            gpio_out <= '0;
            gpio_oeb <= '1;
            rr_ptr   <= nxt_ptr;
          end else begin
            gpio_out <= own_out;
            gpio_oeb <= own_oeb;
          end
        end
        TURN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef T03_GPIO_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0]      hold;
  logic [NREQ-1:0] mask;

  assign cand      = req & ~mask;
  assign force_rel = (state == OWN) && own_req &&
                     (hold == HOLD_LAST);

  // A timed-out owner stays masked until it lets go of req.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hold    <= '0;
      mask    <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= en && force_rel;
      if (en && force_rel) begin
        mask <= (mask & req) | grant;
      end else begin
        mask <= mask & req;
      end
      if (en && state == OWN) begin
        hold <= hold + 8'd1;
      end else begin
        hold <= '0;
      end
    end
  end
`else
  assign cand      = req;
  assign force_rel = 1'b0;
  // Never true for a legal MAX_HOLD; the pulse is not built here.
  assign timeout   = (MAX_HOLD < 0);
`endif

endmodule

// File: tb/tb_t03_gpio_arbiter.sv
// tb_t03_gpio_arbiter: directed vectors for the GPIO bank arbiter.
// Also covers the hold limit when T03_GPIO_ARB_TIMEOUT_EN is defined.
module tb_t03_gpio_arbiter;

  localparam int N = 4;
  localparam int W = 34;
`ifdef T03_GPIO_ARB_TIMEOUT_EN
  localparam int MH = 4;
`else
  localparam int MH = 255;
`endif

  localparam logic [W-1:0] Z   = '1;
  localparam logic [W-1:0] ZO  = '0;
  localparam logic [W-1:0] S0O = 34'h0_1111_1111;
  localparam logic [W-1:0] S1O = 34'h2_2222_2222;
  localparam logic [W-1:0] S2O = 34'h1_2345_6789;
  localparam logic [W-1:0] S3O = 34'h3_3333_3333;
  localparam logic [W-1:0] S0E = 34'h0_0000_00FF;
  localparam logic [W-1:0] S1E = 34'h0_0000_0000;
  localparam logic [W-1:0] S2E = 34'h0_0000_0000;
  localparam logic [W-1:0] S3E = 34'h3_0000_0000;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic           en = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_out;
  logic [N*W-1:0] req_oeb;
  logic [W-1:0]   gpio_out;
  logic [W-1:0]   gpio_oeb;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout;

  assign req_out = {S3O, S2O, S1O, S0O};
  assign req_oeb = {S3E, S2E, S1E, S0E};

  t03_gpio_arbiter #(
    .NREQ(N),
    .WIDTH(W),
    .MAX_HOLD(MH)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .en(en),
    .req(req),
    .req_out(req_out),
    .req_oeb(req_oeb),
    .gpio_out(gpio_out),
    .gpio_oeb(gpio_oeb),
    .grant(grant),
    .busy(busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] g;
    logic         b;
    logic [W-1:0] o;
    logic [W-1:0] e;
  } vec_t;

  vec_t tab[22];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pins(input string tag,
                          input logic [N-1:0] g,
                          input logic b,
                          input logic [W-1:0] o,
                          input logic [W-1:0] e);
    chk({tag, ".grant"}, 64'(grant), 64'(g));
    chk({tag, ".busy"}, 64'(busy), 64'(b));
    chk({tag, ".out"}, 64'(gpio_out), 64'(o));
    chk({tag, ".oeb"}, 64'(gpio_oeb), 64'(e));
    chk({tag, ".tmo"}, 64'(timeout), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] rr_exp [5];
    logic [N-1:0] g;
    int cnt;

    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    tab[0]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, ZO,  Z};
    tab[1]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, ZO,  Z};
    tab[2]  = '{1'b1, 4'b0100, 4'b0100, 1'b1, ZO,  Z};
    tab[3]  = '{1'b1, 4'b0100, 4'b0100, 1'b1, S2O, S2E};
    tab[4]  = '{1'b1, 4'b0100, 4'b0100, 1'b1, S2O, S2E};
    tab[5]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, ZO,  Z};
    tab[6]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, ZO,  Z};
    tab[7]  = '{1'b1, 4'b0010, 4'b0010, 1'b1, ZO,  Z};
    tab[8]  = '{1'b1, 4'b0010, 4'b0010, 1'b1, S1O, S1E};
    tab[9]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, ZO,  Z};
    tab[10] = '{1'b1, 4'b1000, 4'b0000, 1'b0, ZO,  Z};
    tab[11] = '{1'b1, 4'b1000, 4'b1000, 1'b1, ZO,  Z};
    tab[12] = '{1'b1, 4'b1000, 4'b1000, 1'b1, S3O, S3E};
    tab[13] = '{1'b1, 4'b0011, 4'b0000, 1'b1, ZO,  Z};
    tab[14] = '{1'b1, 4'b0011, 4'b0000, 1'b0, ZO,  Z};
    tab[15] = '{1'b1, 4'b0011, 4'b0001, 1'b1, ZO,  Z};
    tab[16] = '{1'b1, 4'b0011, 4'b0001, 1'b1, S0O, S0E};
    tab[17] = '{1'b1, 4'b0010, 4'b0000, 1'b1, ZO,  Z};
    tab[18] = '{1'b1, 4'b0011, 4'b0000, 1'b0, ZO,  Z};
    tab[19] = '{1'b1, 4'b0011, 4'b0010, 1'b1, ZO,  Z};
    tab[20] = '{1'b1, 4'b0000, 4'b0000, 1'b1, ZO,  Z};
    tab[21] = '{1'b1, 4'b0000, 4'b0000, 1'b0, ZO,  Z};

    nrst = 1'b0;
    en   = 1'b1;
    req  = 4'b1111;
    #12;
    chk_pins("reset", 4'b0000, 1'b0, ZO, Z);
    tick();
    chk_pins("reset_edge", 4'b0000, 1'b0, ZO, Z);
    en   = 1'b0;
    nrst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      en  = tab[i].en;
      req = tab[i].req;
      tick();
      chk_pins($sformatf("vec%0d", i), tab[i].g,
               tab[i].b, tab[i].o, tab[i].e);
    end

    // Round robin from a fresh pointer, each owner holding 3 cycles.
    nrst = 1'b0;
    #2;
    nrst = 1'b1;
    en   = 1'b1;
    req  = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      cnt = 0;
      while (grant == '0 && cnt < 8) begin
        tick();
        cnt++;
      end
      chk($sformatf("rr%0d.grant", n), 64'(grant),
          64'(rr_exp[n]));
      if (n > 0) begin
        chk($sformatf("rr%0d.gap", n), 64'(cnt), 64'd2);
      end
      g = grant;
      tick();
      tick();
      req = 4'b1111 & ~g;
      tick();
      chk($sformatf("rr%0d.turn_busy", n), 64'(busy), 64'd1);
      chk($sformatf("rr%0d.turn_oeb", n),
          64'(gpio_oeb), 64'(Z));
      req = 4'b1111;
    end

    // Enable drop while requester 1 owns the bank.
    req = 4'b0010;
    cnt = 0;
    while (grant == '0 && cnt < 8) begin
      tick();
      cnt++;
    end
    chk("en.grant", 64'(grant), 64'(4'b0010));
    tick();
    chk_pins("en.own", 4'b0010, 1'b1, S1O, S1E);
    en = 1'b0;
    tick();
    chk_pins("en.low", 4'b0000, 1'b0, ZO, Z);
    en = 1'b1;
    tick();
    chk_pins("en.regrant", 4'b0010, 1'b1, ZO, Z);
    tick();
    chk_pins("en.reown", 4'b0010, 1'b1, S1O, S1E);

    // Asynchronous reset mid-ownership clears the pointer.
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    tick();
    chk("rst.pre_grant", 64'(grant), 64'(4'b0100));
    tick();
    chk("rst.pre_out", 64'(gpio_out), 64'(S2O));
    #2;
    nrst = 1'b0;
    #1;
    chk_pins("rst.mid", 4'b0000, 1'b0, ZO, Z);
    #2;
    nrst = 1'b1;
    req  = 4'b1001;
    tick();
    chk("rst.ptr", 64'(grant), 64'(4'b0001));
    tick();
    chk_pins("rst.own0", 4'b0001, 1'b1, S0O, S0E);

`ifdef T03_GPIO_ARB_TIMEOUT_EN
    nrst = 1'b0;
    #2;
    nrst = 1'b1;
    req  = 4'b0011;
    tick();
    chk("tmo.grant0", 64'(grant), 64'(4'b0001));
    cnt = 0;
    while (timeout == 1'b0 && cnt < 10) begin
      tick();
      cnt++;
    end
    chk("tmo.cycles", 64'(cnt), 64'd4);
    chk("tmo.grant_off", 64'(grant), 64'd0);
    chk("tmo.busy", 64'(busy), 64'd1);
    chk("tmo.oeb", 64'(gpio_oeb), 64'(Z));
    tick();
    chk("tmo.pulse_end", 64'(timeout), 64'd0);
    tick();
    chk("tmo.grant1", 64'(grant), 64'(4'b0010));
    req = 4'b0001;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("tmo.masked%0d", k),
          64'(grant), 64'd0);
    end
    req = 4'b0000;
    tick();
    req = 4'b0001;
    tick();
    chk("tmo.unmask", 64'(grant), 64'(4'b0001));
`else
    chk("tmo.tied", 64'(timeout), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
